clock_divider_multi: RTL and testbench

Multi-channel, runtime-programmable clock divider for the VGA controller and neighbouring display blocks, generalising the fixed single-output divider. It derives NUM_CH independent divided square waves and single-cycle tick strobes from the one system clock. Each channel's divisor can be reprogrammed through a simple write handshake. A new divisor takes effect only at that channel's period boundary, so no channel ever produces a runt pulse. Typical use: channel 0 at DEFAULT_DIV=2 gives the 25 MHz pixel enable from 50 MHz; other channels drive slower timebases.

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clkdiv_channel.sv | 72 +++++++
 rtl/clock_divider_multi.sv | 62 ++++++
 tb/tb_clock_divider_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int MIN_DIV       = 2;
  localparam int DEFAULT_DIV_W = 8;

  // Length of the high phase: ceil(max(d, MIN_DIV) / 2).
  function automatic logic [31:0] high_len(input logic [31:0] d);
    logic [31:0] d_eff;
    d_eff = (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    return (d_eff + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending divisor and registered outputs.
// Pending divisors load only at a period boundary so a running output never sees a runt pulse.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DEFAULT_DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_val,
  output logic             o_pending,
  output logic             o_clk_out,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_run;
  logic             r_clk_out;
  logic             r_tick;

  logic [DIV_W-1:0] w_div_eff;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_cnt_next;
  logic             w_wrap;
  logic             w_boundary;
  logic             w_apply;

  assign w_div_eff  = (r_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : r_div;
  assign w_wrap     = (r_cnt == w_div_eff - DIV_W'(1));
  // A fresh enable, a sync pulse or a wrap all start a new period at cnt=0.
  assign w_boundary = i_sync | ~r_run | w_wrap;
  assign w_apply    = r_pend & (~i_en | w_boundary);
  assign w_div_next = w_apply ? r_pend_val : r_div;
  assign w_cnt_next = (~i_en | w_boundary) ? '0 : r_cnt + DIV_W'(1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div      <= DIV_W'(DEFAULT_DIV);
      r_cnt      <= '0;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_run      <= 1'b0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_run     <= i_en;
      r_cnt     <= w_cnt_next;
      r_div     <= w_div_next;
      r_tick    <= i_en & w_boundary;
      r_clk_out <= i_en & (32'(w_cnt_next) < high_len(32'(w_div_next)));
      // Writes are only qualified while no value is pending, so capture and apply never coincide.
      if (i_wr) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_wr_val;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pending = r_pend;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH runtime-programmable clock dividers sharing one divisor write port.
// Optional macro CLKDIV_SYNC_EN adds a sync input that phase-aligns all enabled channels.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int DIV_W       = DEFAULT_DIV_W,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              div_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // An out-of-range channel index never matches, so it reads not-ready and writes nothing.
  always_comb begin
    div_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (div_ch == CH_W'(i)) div_ready = ~w_pending[i];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_wr[gi] = div_wr & div_ready & (div_ch == CH_W'(gi));

    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .i_rst_n   (reset),
      .i_en      (en[gi]),
      .i_sync    (w_sync),
      .i_wr      (w_wr[gi]),
      .i_wr_val  (div_val),
      .o_pending (w_pending[gi]),
      .o_clk_out (clk_out[gi]),
      .o_tick    (tick[gi])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (two channels, 8-bit divisors).
// Build with CLKDIV_SYNC_EN defined to also exercise the sync alignment scenario.
module tb_clock_divider_multi;

  logic       clk;
  logic       reset;
  logic [1:0] en;
  logic       div_wr;
  logic [0:0] div_ch;
  logic [7:0] div_val;
  logic       div_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic       sync;
`endif

  int errors = 0;
  int checks = 0;

  clock_divider_multi #(
    .NUM_CH      (2),
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .en        (en),
    .div_wr    (div_wr),
    .div_ch    (div_ch),
    .div_val   (div_val),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Rising edges at 10, 20, 30 ... ns.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    en      = 2'b11;
    div_wr  = 1'b0;
    div_ch  = 1'b0;
    div_val = 8'd0;
`ifdef CLKDIV_SYNC_EN
    sync    = 1'b0;
`endif
    #12;
    checks++;
    if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out: got %b expected %b", clk_out, 2'b00); end
    checks++;
    if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b expected %b", tick, 2'b00); end
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", div_ready); end
    #13;
    reset = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_default;
    logic [1:0] exp;
    for (int k = 0; k < 7; k++) begin
      step();
      exp = (k % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (clk_out !== exp) begin errors++; $display("FAIL default_clk_out k=%0d: got %b expected %b", k, clk_out, exp); end
      checks++;
      if (tick !== exp) begin errors++; $display("FAIL default_tick k=%0d: got %b expected %b", k, tick, exp); end
    end
  endtask

  task automatic test_write_ch1;
    logic [1:0] exp_t;
    logic [1:0] exp_c;
    div_ch  = 1'b1;
    div_val = 8'd5;
    div_wr  = 1'b1;
    $display("write ch1 div=5");
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b expected 1", div_ready); end
    step();
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_pending: got %b expected 0", div_ready); end
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b00) begin errors++; $display("FAIL wr_ch1_midperiod: got %b expected 00", {clk_out[1], tick[1]}); end
    div_val = 8'd7;
    $display("write ch1 div=7 while pending");
    step();
    div_wr = 1'b0;
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_applied: got %b expected 1", div_ready); end
    for (int j = 0; j < 11; j++) begin
      if (j > 0) step();
      exp_t = {(j % 5 == 0), (j % 2 == 0)};
      exp_c = {(j % 5 < 3), (j % 2 == 0)};
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL div5_tick j=%0d: got %b expected %b", j, tick, exp_t); end
      checks++;
      if (clk_out !== exp_c) begin errors++; $display("FAIL div5_clk_out j=%0d: got %b expected %b", j, clk_out, exp_c); end
    end
  endtask

  task automatic test_clamp;
    logic [7:0] vals [2];
    vals[0] = 8'd0;
    vals[1] = 8'd1;
    for (int v = 0; v < 2; v++) begin
      div_ch  = 1'b0;
      div_val = vals[v];
      div_wr  = 1'b1;
      $display("write ch0 div=%0d", vals[v]);
      step();
      div_wr = 1'b0;
      checks++;
      if (div_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready_pending v=%0d: got %b expected 0", vals[v], div_ready); end
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== 2'b11) begin errors++; $display("FAIL clamp_apply v=%0d: got %b expected 11", vals[v], {clk_out[0], tick[0]}); end
      checks++;
      if (div_ready !== 1'b1) begin errors++; $display("FAIL clamp_ready_applied v=%0d: got %b expected 1", vals[v], div_ready); end
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== 2'b00) begin errors++; $display("FAIL clamp_low v=%0d: got %b expected 00", vals[v], {clk_out[0], tick[0]}); end
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== 2'b11) begin errors++; $display("FAIL clamp_wrap v=%0d: got %b expected 11", vals[v], {clk_out[0], tick[0]}); end
    end
  endtask

  task automatic test_enable;
    logic exp_t;
    logic exp_c;
    en = 2'b01;
    step();
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b00) begin errors++; $display("FAIL en_drop: got %b expected 00", {clk_out[1], tick[1]}); end
    div_ch  = 1'b1;
    div_val = 8'd3;
    div_wr  = 1'b1;
    $display("write ch1 div=3 while disabled");
    step();
    div_wr = 1'b0;
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL dis_ready_pending: got %b expected 0", div_ready); end
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b00) begin errors++; $display("FAIL dis_outputs: got %b expected 00", {clk_out[1], tick[1]}); end
    step();
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL dis_ready_applied: got %b expected 1", div_ready); end
    en = 2'b11;
    for (int j = 0; j < 7; j++) begin
      step();
      exp_t = (j % 3 == 0);
      exp_c = (j % 3 < 2);
      checks++;
      if (tick[1] !== exp_t) begin errors++; $display("FAIL reen_tick j=%0d: got %b expected %b", j, tick[1], exp_t); end
      checks++;
      if (clk_out[1] !== exp_c) begin errors++; $display("FAIL reen_clk_out j=%0d: got %b expected %b", j, clk_out[1], exp_c); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] tick_tbl;
    logic [7:0] clk_tbl;
    tick_tbl = 8'b1000_1001;
    clk_tbl  = 8'b1001_1011;
    step();
    step();
    div_ch  = 1'b1;
    div_val = 8'd4;
    div_wr  = 1'b1;
    $display("write ch1 div=4 on wrap cycle");
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b expected 1", div_ready); end
    for (int j = 0; j < 8; j++) begin
      step();
      div_wr = 1'b0;
      checks++;
      if (tick[1] !== tick_tbl[j]) begin errors++; $display("FAIL b2b_tick j=%0d: got %b expected %b", j, tick[1], tick_tbl[j]); end
      checks++;
      if (clk_out[1] !== clk_tbl[j]) begin errors++; $display("FAIL b2b_clk_out j=%0d: got %b expected %b", j, clk_out[1], clk_tbl[j]); end
      if (j == 0) begin
        checks++;
        if (div_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b expected 0", div_ready); end
      end
      if (j == 3) begin
        checks++;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_applied: got %b expected 1", div_ready); end
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync;
    logic [1:0] exp_t;
    logic [1:0] exp_c;
    div_ch  = 1'b0;
    div_val = 8'd3;
    div_wr  = 1'b1;
    $display("write ch0 div=3 then sync");
    step();
    div_wr = 1'b0;
    sync   = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      sync  = 1'b0;
      exp_t = {(j % 4 == 0), (j % 3 == 0)};
      exp_c = {(j % 4 < 2), (j % 3 < 2)};
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL sync_tick j=%0d: got %b expected %b", j, tick, exp_t); end
      checks++;
      if (clk_out !== exp_c) begin errors++; $display("FAIL sync_clk_out j=%0d: got %b expected %b", j, clk_out, exp_c); end
    end
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL sync_ready: got %b expected 1", div_ready); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [1:0] exp;
    div_ch  = 1'b1;
    div_val = 8'd9;
    div_wr  = 1'b1;
    $display("write ch1 div=9 then reset");
    step();
    div_wr = 1'b0;
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_pending: got %b expected 0", div_ready); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick} !== 4'b0000) begin errors++; $display("FAIL rstmid_outputs: got %b expected 0000", {clk_out, tick}); end
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL rstmid_pending_lost: got %b expected 1", div_ready); end
    #2;
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      exp = (j % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (clk_out !== exp) begin errors++; $display("FAIL rstmid_clk_out j=%0d: got %b expected %b", j, clk_out, exp); end
      checks++;
      if (tick !== exp) begin errors++; $display("FAIL rstmid_tick j=%0d: got %b expected %b", j, tick, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_write_ch1();
    test_clamp();
    test_enable();
    test_back_to_back();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
